// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default sizes and port-field slicing for register_file_mp
//   rf_state_t  : clear-engine FSM states
//   RF_*        : default width/depth/port-count constants
//   slice_field : extracts field p of width w from a packed port bus
package regfile_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NUM_RD = 2;
  localparam int RF_BUS_W = 64;
  function automatic logic [31:0] slice_field(input logic [RF_BUS_W-1:0] bus, input int p, input int w);
    logic [RF_BUS_W-1:0] mask;
    mask = (RF_BUS_W'(1) << w) - RF_BUS_W'(1);
    return 32'((bus >> (p * w)) & mask);
  endfunction
endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: sequential clear engine, zeroes one entry per cycle
//   clock, reset : clock and asynchronous active-high reset
//   clear_req    : start a clear (ignored while busy)
//   busy         : high for exactly DEPTH cycles while clearing
//   clear_done   : one-cycle pulse after the last entry is cleared
//   clr_en       : zero entry clr_idx at the next edge
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);
  rf_state_t state, state_n;
  logic [ADDR_W-1:0] idx_n;
  logic done_n, last;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RF_IDLE;
      clr_idx <= '0;
      clear_done <= 1'b0;
    end else begin
      state <= state_n;
      clr_idx <= idx_n;
      clear_done <= done_n;
    end
  end
  always_comb begin
    last = 32'(clr_idx) == DEPTH - 1;
    busy = state == RF_CLEAR;
    clr_en = busy;
    state_n = busy ? (last ? RF_IDLE : RF_CLEAR) : (clear_req ? RF_CLEAR : RF_IDLE);
    idx_n = (busy && !last) ? clr_idx + 1'b1 : '0;
    done_n = busy && last;
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file with registered reads and clear engine
//   clock, reset           : clock and asynchronous active-high reset (clears all state)
//   rd_en/rd_addr          : per-port read request and packed addresses
//   rd_data/rd_valid       : packed registered read data and per-port valid, 1 cycle latency
//   write_enable/write_reg/write_data : write port, committed only in IDLE and in range
//   wr_drop                : registered pulse for a discarded write (busy or out of range)
//   clear_req/busy/clear_done : sequential clear handshake
// Build option: REGFILE_BYPASS_EN forwards a same-edge committed write to matching reads.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  output logic                     wr_drop,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     clear_done
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [DATA_W-1:0] rv [NUM_RD];
  logic [ADDR_W-1:0] clr_idx;
  logic clr_en, wr_in_range, wr_commit;
  regfile_clear_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clock(clock),
    .reset(reset),
    .clear_req(clear_req),
    .busy(busy),
    .clear_done(clear_done),
    .clr_en(clr_en),
    .clr_idx(clr_idx)
  );
  // Writes to the hardwired zero entry are swallowed without counting as drops.
  always_comb begin
    wr_in_range = 32'(write_reg) < DEPTH;
    wr_commit = write_enable && !busy && wr_in_range && !(ZERO_REG != 0 && write_reg == '0);
  end
  // Read value uses pre-edge storage, so clear-engine zeroing is never forwarded.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p] = ADDR_W'(slice_field(RF_BUS_W'(rd_addr), p, ADDR_W));
      rv[p] = (32'(ra[p]) >= DEPTH || (ZERO_REG != 0 && ra[p] == '0)) ? '0 :
              (BYP && wr_commit && write_reg == ra[p]) ? write_data : mem[ra[p]];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_commit) mem[write_reg] <= write_data;
      if (clr_en) mem[clr_idx] <= '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      rd_valid <= '0;
      wr_drop <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      wr_drop <= write_enable && (busy || !wr_in_range);
      for (int p = 0; p < NUM_RD; p++)
        if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= rv[p];
    end
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: randomized and directed checks of register_file_mp against a behavioural model
module tb_register_file_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int D = 32;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] ren;
  logic [4:0] ra0, ra1, wa;
  logic we, creq;
  logic [31:0] wdat;
  logic [63:0] rdata;
  logic [1:0] rvalid;
  logic drop, busy, done;
  logic [1:0] ren1;
  logic [9:0] raddr1;
  logic we1;
  logic [4:0] wa1;
  logic [31:0] wdat1;
  logic [63:0] rdata1;
  logic [1:0] rvalid1;
  logic drop1, busy1, done1;
  int checks = 0;
  int failures = 0;
  logic [31:0] m [D];
  logic [31:0] hold [2];
  int left, pos;
  always #5 clk = ~clk;
  register_file_mp dut (
    .clock(clk), .reset(rst), .rd_en(ren), .rd_addr({ra1, ra0}), .rd_data(rdata),
    .rd_valid(rvalid), .write_enable(we), .write_reg(wa), .write_data(wdat),
    .wr_drop(drop), .clear_req(creq), .busy(busy), .clear_done(done)
  );
  register_file_mp #(.DEPTH(20)) dut20 (
    .clock(clk), .reset(rst), .rd_en(ren1), .rd_addr(raddr1), .rd_data(rdata1),
    .rd_valid(rvalid1), .write_enable(we1), .write_reg(wa1), .write_data(wdat1),
    .wr_drop(drop1), .clear_req(1'b0), .busy(busy1), .clear_done(done1)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i] = 0;
    hold[0] = 0;
    hold[1] = 0;
    left = 0;
    pos = 0;
  endtask
  task automatic idle_inputs();
    ren = 0; ra0 = 0; ra1 = 0; we = 0; wa = 0; wdat = 0; creq = 0;
  endtask
  // One clock: predict outputs from the model, advance the model, then compare after the edge.
  task automatic step();
    logic bp, commit, edrop, edone;
    logic [4:0] a;
    bp = left > 0;
    edrop = we && (bp || int'(wa) >= D);
    commit = we && !bp && int'(wa) < D && wa != 0;
    for (int p = 0; p < 2; p++) begin
      a = p == 0 ? ra0 : ra1;
      if (ren[p]) hold[p] = (a == 0) ? 0 : (BYP && commit && wa == a) ? wdat : m[a];
    end
    edone = 0;
    if (commit) m[wa] = wdat;
    if (bp) begin
      m[pos] = 0;
      pos++;
      left--;
      edone = left == 0;
    end else if (creq) begin
      left = D;
      pos = 0;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rvalid), 32'(ren));
    chk("rd_data0", rdata[31:0], hold[0]);
    chk("rd_data1", rdata[63:32], hold[1]);
    chk("wr_drop", 32'(drop), 32'(edrop));
    chk("busy", 32'(busy), 32'(left > 0));
    chk("clear_done", 32'(done), 32'(edone));
  endtask
  initial begin
    int bcnt, dcnt;
    idle_inputs();
    ren1 = 0; raddr1 = 0; we1 = 0; wa1 = 0; wdat1 = 0;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rdata[31:0] | rdata[63:32], 0);
    chk("reset_flags", {27'd0, rvalid, drop, busy, done}, 0);
    rst = 0;
    // Fresh reads after reset.
    ren = 2'b11; ra0 = 5; ra1 = 17;
    step();
    chk("lit_reset_read", rdata[31:0] | rdata[63:32], 0);
    chk("lit_reset_valid", 32'(rvalid), 32'd3);
    // Basic write then read.
    idle_inputs();
    we = 1; wa = 7; wdat = 32'hDEADBEEF;
    step();
    idle_inputs();
    ren = 2'b01; ra0 = 7;
    step();
    chk("lit_read7", rdata[31:0], 32'hDEADBEEF);
    // Hardwired zero entry.
    idle_inputs();
    we = 1; wa = 0; wdat = 32'h55;
    step();
    chk("lit_zero_wr_nodrop", 32'(drop), 0);
    idle_inputs();
    ren = 2'b10; ra1 = 0;
    step();
    chk("lit_read0", rdata[63:32], 0);
    // Same-edge write and read.
    idle_inputs();
    we = 1; wa = 9; wdat = 32'h1;
    step();
    we = 1; wa = 9; wdat = 32'h1234; ren = 2'b01; ra0 = 9;
    step();
    chk("lit_same_edge", rdata[31:0], BYP ? 32'h1234 : 32'h1);
    idle_inputs();
    ren = 2'b01; ra0 = 9;
    step();
    chk("lit_after_write", rdata[31:0], 32'h1234);
    // Randomized traffic including occasional clears.
    for (int k = 0; k < 600; k++) begin
      ren = 2'($urandom);
      ra0 = 5'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom);
      we = $urandom_range(0, 2) != 0;
      wa = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom);
      wdat = $urandom;
      creq = $urandom_range(0, 60) == 0;
      step();
    end
    idle_inputs();
    while (left > 0) step();
    // Fill, then clear with a write attempted mid-clear.
    for (int i = 0; i < D; i++) begin
      we = 1; wa = 5'(i); wdat = i;
      step();
    end
    idle_inputs();
    ren = 2'b11; ra0 = 31; ra1 = 3;
    step();
    chk("lit_fill31", rdata[31:0], 31);
    idle_inputs();
    creq = 1;
    step();
    bcnt = busy ? 1 : 0;
    dcnt = done ? 1 : 0;
    creq = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        we = 1; wa = 3; wdat = 32'hAB;
      end else we = 0;
      step();
      if (k == 5) chk("lit_busy_drop", 32'(drop), 1);
      bcnt += busy ? 1 : 0;
      dcnt += done ? 1 : 0;
    end
    chk("lit_busy_cycles", bcnt, 32);
    chk("lit_done_pulses", dcnt, 1);
    idle_inputs();
    for (int i = 0; i < D; i++) begin
      ren = 2'b11; ra0 = 5'(i); ra1 = 5'(D - 1 - i);
      step();
      chk("lit_cleared", rdata[31:0] | rdata[63:32], 0);
    end
    // Reset in the middle of a clear.
    idle_inputs();
    for (int i = 1; i < D; i++) begin
      we = 1; wa = 5'(i); wdat = $urandom | 1;
      step();
    end
    idle_inputs();
    creq = 1;
    step();
    creq = 0;
    repeat (10) step();
    #2;
    rst = 1;
    #1;
    chk("lit_rst_busy", 32'(busy), 0);
    chk("lit_rst_done", 32'(done), 0);
    model_reset();
    step();
    rst = 0;
    for (int i = 0; i < D; i++) begin
      ren = 2'b11; ra0 = 5'(i); ra1 = 5'(i);
      step();
      chk("lit_rst_entries", rdata[31:0] | rdata[63:32], 0);
      if (i == 12) chk("lit_rst_no_done", 32'(done), 0);
    end
    // Depth-20 instance: out-of-range write and read.
    idle_inputs();
    we1 = 1; wa1 = 25; wdat1 = 32'hCAFE;
    step();
    chk("d20_drop", 32'(drop1), 1);
    we1 = 1; wa1 = 19; wdat1 = 32'hABC;
    step();
    chk("d20_nodrop", 32'(drop1), 0);
    we1 = 0; ren1 = 2'b11; raddr1 = {5'd25, 5'd19};
    step();
    chk("d20_valid", 32'(rvalid1), 3);
    chk("d20_read19", rdata1[31:0], 32'hABC);
    chk("d20_read25", rdata1[63:32], 0);
    ren1 = 0;
    step();
    chk("d20_valid_low", 32'(rvalid1), 0);
    chk("d20_hold", rdata1[31:0], 32'hABC);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the CSE_BUBBLE datapath, the next generation of the 32x32 register file. It has configurable width, depth and read-port count, and registered read ports with a valid flag. It also adds an optional hardwired zero entry and a sequential clear engine with a busy/done handshake. It sits between decode, which supplies read addresses, and writeback, which supplies write data.

## Interface
- DATA_W, 32, entry width in bits
- DEPTH, 32, number of entries (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- clock  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- rd_en  input  NUM_RD  per-port read request
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  packed registered read data
- rd_valid  output  NUM_RD  per-port data valid, one cycle after rd_en
- write_enable  input  1  write request
- write_reg  input  ADDR_W  write address
- write_data  input  DATA_W  write data
- wr_drop  output  1  one-cycle pulse: the write was discarded (busy or out of range)
- clear_req  input  1  start sequential clear of all entries
- busy  output  1  high while clearing
- clear_done  output  1  one-cycle pulse after the last entry is cleared

## Operation
- Reset: every entry is 0, rd_data is 0, rd_valid is 0, wr_drop is 0, busy is 0, clear_done is 0, and the FSM is IDLE. No initial-value preload.
- Write: in IDLE, with write_enable high and write_reg < DEPTH, the entry is updated at posedge.
- A write to entry 0 with ZERO_REG=1 is silently ignored. It is not a drop.
- A write is dropped, with a wr_drop pulse the next cycle, when write_reg ≥ DEPTH or when busy is high.
- Read: each port is independent. When rd_en[p] is high at posedge, rd_data[p] loads the entry and rd_valid[p] is set for that cycle.
- When rd_en[p] is low, rd_valid[p] goes to 0 and rd_data[p] holds its value.
- Out-of-range read addresses return 0 with valid set.
- Entry 0 reads 0 when ZERO_REG=1.
- Multiple ports may read the same address in the same cycle.
- FSM has two states: IDLE and CLEAR.
  - IDLE→CLEAR on clear_req; the index is set to 0.
  - In CLEAR, one entry is zeroed per cycle, index 0..DEPTH-1.
  - CLEAR→IDLE after entry DEPTH-1 is cleared; clear_done pulses on that transition edge.
- clear_req while busy is ignored.
- Reads are served normally during CLEAR and return current contents.
- clear_req and a valid write in the same IDLE cycle: the write commits, CLEAR starts next cycle, and the entry is later zeroed.
- Reset asserted mid-clear forces IDLE with all entries 0 immediately. No clear_done pulse.

## Timing
- Write-to-storage: committed at the posedge where write_enable is sampled.
- Read latency: 1 cycle. Address at edge N gives data and valid in the cycle after edge N.
- Same-edge read and write to the same address: see Configuration.
- busy rises the cycle after clear_req and stays high for exactly DEPTH cycles.
- A clear occupies DEPTH cycles from request to clear_done.
- wr_drop is registered: it asserts the cycle after the dropped write.
- Clear-engine zeroing is never forwarded to reads in the same cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read sampled at the same edge as a committed write to the same address returns write_data.
  - Forwarding is never applied to dropped writes or to entry 0 with ZERO_REG=1.
- REGFILE_BYPASS_EN undefined: that read returns the old contents, and the new value is visible from the next read.

## Structure
- Package regfile_pkg holds:
  - FSM state enum (RF_IDLE, RF_CLEAR)
  - default width/depth constants
  - the helper function to slice packed port fields
- One sub-module, regfile_clear_ctrl, holds the FSM, clear index counter, busy and clear_done.
- Storage, read ports and bypass logic stay in the top module.

## Test plan
- Reset with no writes, then read ports 0/1 at addr 5 and 17 → rd_data 0 and 0, with rd_valid 2'b11 one cycle later.
- Write 0xDEADBEEF to addr 7, then read addr 7 the next cycle → 0xDEADBEEF one cycle later. Write 0x55 to addr 0 with ZERO_REG=1, then read addr 0 → 0.
- Same-edge write of 0x1234 to addr 9 and read of addr 9, with addr 9 previously 0x1 → 0x1234 with REGFILE_BYPASS_EN, 0x1 without it.
- Fill all entries with their own index, pulse clear_req → busy high for exactly 32 cycles and clear_done one pulse. A write issued during busy → wr_drop pulse and no change. All entries read 0 afterwards.
- Assert reset at clear index 10 → busy 0 immediately, no clear_done pulse, all entries 0.
- With DEPTH=20, write to addr 25 → wr_drop pulse. Read addr 25 → 0 with valid set.
